// File: rtl/ram_lookup_pkg.sv
// Shared definitions for the RAM lookup controller: read latency of the table
// RAM and the response record carried through the response FIFO.
package ram_lookup_pkg;

  localparam int RAM_LAT = 2;
  localparam int RESP_DW = 8;
  localparam int RESP_TW = 4;

  typedef struct packed {
    logic [RESP_TW-1:0] tag;
    logic [RESP_DW-1:0] data;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_lookup_ctrl_fifo.sv
// In-order response FIFO with a registered head: o_valid/o_data come straight
// from flops and stay put while the head is not popped.
module lookup_resp_fifo
  import ram_lookup_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [RESP_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [RESP_W-1:0] o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  resp_t          r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_valid;
  resp_t          r_head;

  logic           w_pop;
  logic [PW-1:0]  w_rd_ptr_nxt;
  logic [CW-1:0]  w_count_nxt;

  assign w_pop        = i_pop & r_valid;
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_count_nxt  = r_count + CW'(i_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // The next head is either already stored or is the word arriving this cycle
  // (the latter only when it lands in the slot the read pointer moves to).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_head <= (i_push && (r_wr_ptr == w_rd_ptr_nxt)) ? resp_t'(i_push_data)
                                                         : r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/ram_lookup_ctrl.sv
// Controller for a 1RW/1R table RAM: config writes on port A, tagged lookups on
// port B, in-order responses with credit-based backpressure.
module ram_lookup_ctrl
  import ram_lookup_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 8,
  parameter int TWIDTH       = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_valid,
  input  logic [AWIDTH-1:0] cfg_wr_addr,
  input  logic [DWIDTH-1:0] cfg_wr_data,
  output logic              cfg_wr_ready,
  input  logic              req_valid,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [TWIDTH-1:0] req_tag,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_data,
  output logic [TWIDTH-1:0] resp_tag,
  input  logic              resp_ready,
  output logic [AWIDTH-1:0] ram_addr_a,
  output logic [DWIDTH-1:0] ram_wr_data_a,
  output logic              ram_wr_en_a,
  output logic [AWIDTH-1:0] ram_addr_b,
  input  logic [DWIDTH-1:0] ram_q_b
);

  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = $clog2(MAX_WR_BURST + 1);

  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_chk_depth
    $fatal(1, "ram_lookup_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if ((DWIDTH != RESP_DW) || (TWIDTH != RESP_TW)) begin : g_chk_width
    $fatal(1, "ram_lookup_ctrl: DWIDTH/TWIDTH must match the resp_t record");
  end
  if (MAX_WR_BURST < 1) begin : g_chk_burst
    $fatal(1, "ram_lookup_ctrl: MAX_WR_BURST must be at least 1");
  end

  logic [CRW-1:0]    r_credits;
  logic [SW-1:0]     r_wr_streak;
  logic [AWIDTH-1:0] r_ram_addr_a;
  logic [DWIDTH-1:0] r_ram_wr_data_a;
  logic              r_ram_wr_en_a;
  logic [AWIDTH-1:0] r_ram_addr_b;
  logic [RAM_LAT:0]  r_lk_vld_p;
  logic [TWIDTH-1:0] r_lk_tag_p [RAM_LAT+1];

  logic              w_lk_elig;
  logic              w_force_lk;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_pop;
  resp_t             w_push_resp;
  resp_t             w_head_resp;
  logic [RESP_W-1:0] w_head_bits;

  // A waiting lookup is forced through once writes have had their burst.
  assign w_lk_elig    = req_valid & (r_credits != '0);
  assign w_force_lk   = w_lk_elig & (r_wr_streak == SW'(MAX_WR_BURST));
  assign cfg_wr_ready = ~rst & ~w_force_lk;
  assign w_wr_acc     = cfg_wr_valid & cfg_wr_ready;
  assign req_ready    = ~rst & (r_credits != '0) & ~w_wr_acc;
  assign w_rd_acc     = req_valid & req_ready;
  assign w_pop        = resp_valid & resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_streak <= '0;
      r_credits   <= CRW'(FIFO_DEPTH);
    end else begin
      if (w_rd_acc || !w_lk_elig) begin
        r_wr_streak <= '0;
      end else if (w_wr_acc) begin
        r_wr_streak <= r_wr_streak + SW'(1);
      end
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits - CRW'(1);
        2'b01:   r_credits <= r_credits + CRW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Stage p0: RAM port registers, both ports driven the cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_addr_a    <= '0;
      r_ram_wr_data_a <= '0;
      r_ram_wr_en_a   <= 1'b0;
      r_ram_addr_b    <= '0;
    end else begin
      r_ram_wr_en_a <= w_wr_acc;
      if (w_wr_acc) begin
        r_ram_addr_a    <= cfg_wr_addr;
        r_ram_wr_data_a <= cfg_wr_data;
      end
      if (w_rd_acc) begin
        r_ram_addr_b <= req_addr;
      end
    end
  end

  // Stages p0..p(RAM_LAT): {valid,tag} follows the lookup until ram_q_b is live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lk_vld_p <= '0;
    end else begin
      r_lk_vld_p <= {r_lk_vld_p[RAM_LAT-1:0], w_rd_acc};
    end
  end

  always_ff @(posedge clk) begin
    r_lk_tag_p[0] <= req_tag;
    for (int i = 1; i <= RAM_LAT; i++) begin
      r_lk_tag_p[i] <= r_lk_tag_p[i-1];
    end
  end

  assign w_push_resp = '{tag: r_lk_tag_p[RAM_LAT], data: ram_q_b};

  // Response stage: capture RAM data with its tag into the FIFO.
  lookup_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_lk_vld_p[RAM_LAT]),
    .i_push_data (w_push_resp),
    .i_pop       (resp_ready),
    .o_valid     (resp_valid),
    .o_data      (w_head_bits)
  );

  assign w_head_resp   = resp_t'(w_head_bits);
  assign resp_data     = w_head_resp.data;
  assign resp_tag      = w_head_resp.tag;
  assign ram_addr_a    = r_ram_addr_a;
  assign ram_wr_data_a = r_ram_wr_data_a;
  assign ram_wr_en_a   = r_ram_wr_en_a;
  assign ram_addr_b    = r_ram_addr_b;

endmodule
